// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter. Takes an N-bit word over valid/ready, shifts it out
// framed by load_o, then pulses en_o so the downstream receiver presents the assembled word.
module piso_tx #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         flush,
    output logic         serial_out,
    output logic         load_o,
    output logic         en_o,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
    localparam logic [3:0]       LAST_GAP = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_STROBE,
        S_GAP
    } state_t;

    state_t           state, state_n;
    logic [N-1:0]     shreg, shreg_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [3:0]       gap_cnt, gap_cnt_n;
    logic             in_ready_n, serial_n, load_n, en_n, busy_n;
    logic [7:0]       frame_cnt_n;

    // Bit idx of the word in transmit order; MSB_FIRST only changes which end is read.
    function automatic logic pick(input logic [N-1:0] word, input logic [CNT_W-1:0] idx);
        logic [CNT_W-1:0] pos;
        pos = MSB_FIRST ? (LAST_BIT - idx) : idx;
        return word[pos];
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        gap_cnt_n   = gap_cnt;
        serial_n    = 1'b0;
        load_n      = 1'b0;
        en_n        = 1'b0;
        frame_cnt_n = frame_cnt;

        if (flush) begin
            state_n   = S_IDLE;
            bit_cnt_n = '0;
            gap_cnt_n = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg_n   = in_data;
                        bit_cnt_n = '0;
                        serial_n  = pick(in_data, '0);
                        load_n    = 1'b1;
                        state_n   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n   = '0;
                        en_n        = 1'b1;
                        frame_cnt_n = frame_cnt + 8'd1;
                        state_n     = S_STROBE;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        serial_n  = pick(shreg, bit_cnt + 1'b1);
                        load_n    = 1'b1;
                    end
                end
                S_STROBE: begin
                    gap_cnt_n = '0;
                    state_n   = (GAP > 0) ? S_GAP : S_IDLE;
                end
                S_GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state_n = S_IDLE;
                    end else begin
                        gap_cnt_n = gap_cnt + 4'd1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Status flags are registered from the next state so they line up with it.
        in_ready_n = (state_n == S_IDLE);
        busy_n     = (state_n != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together
    // from values sampled at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            in_ready   <= 1'b0;
            serial_out <= 1'b0;
            load_o     <= 1'b0;
            en_o       <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            in_ready   <= in_ready_n;
            serial_out <= serial_n;
            load_o     <= load_n;
            en_o       <= en_n;
            busy       <= busy_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (MSB-first, LSB-first, MSB-first with GAP=2) driven
// with directed and random words, checked against a frame-level reference model.
module tb_piso_tx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst       [3];
    logic         in_valid  [3];
    logic [N-1:0] in_data   [3];
    logic         flush     [3];
    logic         in_ready  [3];
    logic         serial_out[3];
    logic         load_o    [3];
    logic         en_o      [3];
    logic         busy      [3];
    logic [7:0]   frame_cnt [3];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        piso_tx #(
            .N        (N),
            .MSB_FIRST(g != 1),
            .GAP      ((g == 2) ? 2 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_data   (in_data[g]),
            .in_ready  (in_ready[g]),
            .flush     (flush[g]),
            .serial_out(serial_out[g]),
            .load_o    (load_o[g]),
            .en_o      (en_o[g]),
            .busy      (busy[g]),
            .frame_cnt (frame_cnt[g])
        );
    end

    function automatic bit msb_of(input int d);
        return d != 1;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    // Bit expected on the wire at position i of a frame.
    function automatic logic exp_bit(input logic [N-1:0] w, input int i, input bit msb);
        int sh;
        sh = msb ? (N - 1 - i) : i;
        return logic'((w >> sh) & 1);
    endfunction

    function automatic logic [N-1:0] reverse(input logic [N-1:0] w);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = w[N-1-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check($sformatf("d%0d_%s_load", d, tag), 8'(load_o[d]), 8'd0);
        check($sformatf("d%0d_%s_serial", d, tag), 8'(serial_out[d]), 8'd0);
        check($sformatf("d%0d_%s_en", d, tag), 8'(en_o[d]), 8'd0);
    endtask

    // Sends one word on instance d. Entered and left at a negedge; leaves in the cycle
    // where in_ready is back high. hold keeps in_valid up with nxt queued behind w.
    // flush_at = k (1..N) raises flush in cycle T0+k; 0 = no flush.
    task automatic send_frame(input int d, input logic [N-1:0] w, input logic [N-1:0] nxt,
                              input bit hold, input int flush_at, output int t0);
        int           waited;
        logic [N-1:0] rx;
        bit           msb;
        msb    = msb_of(d);
        waited = 0;
        while (in_ready[d] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("d%0d_ready_wait", d), 8'(in_ready[d]), 8'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = w;
        t0          = cyc;
        rx          = '0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (hold) begin
                in_data[d] = nxt;
            end else begin
                in_valid[d] = 1'b0;
                in_data[d]  = (i == 0) ? 4'hF : N'($urandom);
            end
            check($sformatf("d%0d_load_b%0d", d, i), 8'(load_o[d]), 8'd1);
            check($sformatf("d%0d_serial_b%0d", d, i), 8'(serial_out[d]), 8'(exp_bit(w, i, msb)));
            check($sformatf("d%0d_en_b%0d", d, i), 8'(en_o[d]), 8'd0);
            check($sformatf("d%0d_ready_b%0d", d, i), 8'(in_ready[d]), 8'd0);
            check($sformatf("d%0d_busy_b%0d", d, i), 8'(busy[d]), 8'd1);
            rx = {rx[N-2:0], serial_out[d]};
            if (flush_at == i + 1) begin
                flush[d] = 1'b1;
                @(negedge clk);
                flush[d] = 1'b0;
                check_idle_outputs(d, "flush");
                check($sformatf("d%0d_flush_ready", d), 8'(in_ready[d]), 8'd1);
                check($sformatf("d%0d_flush_busy", d), 8'(busy[d]), 8'd0);
                @(negedge clk);
                check($sformatf("d%0d_flush_no_en", d), 8'(en_o[d]), 8'd0);
                check($sformatf("d%0d_flush_cnt", d), frame_cnt[d], 8'(exp_cnt[d]));
                return;
            end
        end
        @(negedge clk);
        exp_cnt[d] = (exp_cnt[d] + 1) % 256;
        check($sformatf("d%0d_strobe_en", d), 8'(en_o[d]), 8'd1);
        check($sformatf("d%0d_strobe_load", d), 8'(load_o[d]), 8'd0);
        check($sformatf("d%0d_strobe_serial", d), 8'(serial_out[d]), 8'd0);
        check($sformatf("d%0d_strobe_cnt", d), frame_cnt[d], 8'(exp_cnt[d]));
        check($sformatf("d%0d_strobe_ready", d), 8'(in_ready[d]), 8'd0);
        check($sformatf("d%0d_rx_word", d), 8'(rx), 8'(msb ? w : reverse(w)));
        for (int g = 0; g < gap_of(d); g++) begin
            @(negedge clk);
            check_idle_outputs(d, $sformatf("gap%0d", g));
            check($sformatf("d%0d_gap%0d_ready", d, g), 8'(in_ready[d]), 8'd0);
            check($sformatf("d%0d_gap%0d_busy", d, g), 8'(busy[d]), 8'd1);
        end
        @(negedge clk);
        check($sformatf("d%0d_ready_again", d), 8'(in_ready[d]), 8'd1);
        check($sformatf("d%0d_idle_busy", d), 8'(busy[d]), 8'd0);
        check($sformatf("d%0d_idle_en", d), 8'(en_o[d]), 8'd0);
    endtask

    initial begin
        int t_a, t_b, t_tmp;
        for (int d = 0; d < 3; d++) begin
            rst[d]      = 1'b0;
            in_valid[d] = 1'b0;
            in_data[d]  = '0;
            flush[d]    = 1'b0;
        end

        // Reset state, then the first clock after release raises in_ready.
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_idle_outputs(d, "rst");
            check($sformatf("d%0d_rst_ready", d), 8'(in_ready[d]), 8'd0);
            check($sformatf("d%0d_rst_busy", d), 8'(busy[d]), 8'd0);
            check($sformatf("d%0d_rst_cnt", d), frame_cnt[d], 8'd0);
            rst[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_first_ready", d), 8'(in_ready[d]), 8'd1);

        // Basic MSB-first frame and LSB-first frame.
        send_frame(0, 4'b1011, '0, 1'b0, 0, t_tmp);
        send_frame(1, 4'b1000, '0, 1'b0, 0, t_tmp);

        // Back-to-back with GAP=2: acceptances N+2+GAP cycles apart.
        send_frame(2, 4'hA, 4'h5, 1'b1, 0, t_a);
        send_frame(2, 4'h5, '0, 1'b0, 0, t_b);
        check("d2_b2b_spacing", 8'(t_b - t_a), 8'(N + 2 + 2));
        check("d2_b2b_cnt", frame_cnt[2], 8'd2);

        // Input changes during the shift are ignored, then a flush at T0+2.
        send_frame(0, 4'h3, '0, 1'b0, 0, t_tmp);
        send_frame(0, 4'h9, '0, 1'b0, 2, t_tmp);

        // Asynchronous reset dropped between edges in the middle of a frame.
        in_valid[0] = 1'b1;
        in_data[0]  = 4'hC;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("d0_midframe_load", 8'(load_o[0]), 8'd1);
        #2 rst[0] = 1'b0;
        #1;
        check_idle_outputs(0, "arst");
        check("d0_arst_busy", 8'(busy[0]), 8'd0);
        check("d0_arst_cnt", frame_cnt[0], 8'd0);
        check("d0_arst_ready", 8'(in_ready[0]), 8'd0);
        exp_cnt[0] = 0;
        @(negedge clk);
        rst[0] = 1'b1;
        send_frame(0, 4'h6, '0, 1'b0, 0, t_tmp);

        // Random words on every instance, some aborted by a flush.
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) begin
                int fl;
                fl = ($urandom_range(3) == 0) ? int'($urandom_range(N, 1)) : 0;
                send_frame(d, N'($urandom), '0, 1'b0, fl, t_tmp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Upstream feeder for the serial-in/parallel-out receiver stage.
- Accepts an N-bit word over a valid/ready handshake and shifts it out one bit per clock on serial_out, with load_o framing the shift window.
- After the last bit it raises a one-cycle en_o strobe, so the downstream receiver presents the assembled word on its parallel output.
- An optional inter-frame gap and a synchronous flush complete the block.

Parameters:
- N, 4, word width in bits (N >= 2).
- MSB_FIRST, 1, 1 = in_data[N-1] is sent first, 0 = in_data[0] is sent first.
- GAP, 0, idle cycles inserted after en_o before the next word is accepted (0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  N  parallel word.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous abort of the current frame.
- serial_out  output  1  serial bit; drives the downstream serial_in.
- load_o  output  1  high while serial_out carries a valid bit; drives the downstream load.
- en_o  output  1  one-cycle output-enable strobe after the last bit.
- busy  output  1  high in any state other than IDLE.
- frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) drives: state=IDLE, in_ready=0, serial_out=0, load_o=0, en_o=0, busy=0, frame_cnt=0, shift register=0, bit counter=0, gap counter=0.
- First clock after reset release: in_ready=1.
- States: IDLE, SHIFT, STROBE, GAP.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge T0: capture in_data, go to SHIFT, in_ready=0.
- SHIFT, cycles T0+1 .. T0+N:
  - load_o=1.
  - serial_out = captured bit i at cycle T0+1+i; order set by MSB_FIRST.
  - Bit counter runs 0..N-1.
  - After bit N-1, go to STROBE.
- STROBE, cycle T0+N+1:
  - load_o=0, serial_out=0, en_o=1 for exactly one cycle.
  - frame_cnt increments.
  - Next state is GAP if GAP>0, else IDLE.
- GAP: GAP cycles with all strobes low, then IDLE.
- Handshake timing:
  - in_ready is high again in cycle T0+N+2+GAP.
  - Back-to-back throughput is one word per N+2+GAP cycles.
- in_data / in_valid changes while busy are ignored; the captured word is stable for the whole frame.
- With MSB_FIRST=1 and a receiver that shifts left inserting at bit 0, the receiver's parallel output equals the sent in_data.
- flush=1 in any state:
  - Next cycle: state=IDLE, load_o=0, serial_out=0, en_o=0, in_ready=1.
  - frame_cnt is not incremented and no partial en_o is produced.
  - flush has priority over a simultaneous handshake in IDLE; the word is not accepted.
- Reset mid-frame: outputs go to reset values immediately, without waiting for clk.
- busy = (state != IDLE).

Test Plan:
- Basic frame: reset, release, in_data=4'b1011 with in_valid for one cycle at T0 -> load_o high T0+1..T0+4; serial_out sequence 1,0,1,1; en_o=1 only at T0+5; frame_cnt=1; in_ready=1 at T0+6; downstream receiver parallel_out=1011.
- LSB-first: MSB_FIRST=0, in_data=4'b1000 -> serial_out sequence 0,0,0,1; en_o at T0+5.
- Back-to-back with gap: GAP=2, in_valid held high with words 4'hA then 4'h5 -> second acceptance exactly 8 cycles after the first; serial streams 1010 then 0101; two en_o pulses 8 cycles apart; frame_cnt=2.
- Ignored input: change in_data to 4'hF during SHIFT of 4'h3 -> serial_out is still 0,0,1,1; in_ready stays 0 throughout.
- Flush: assert flush for one cycle at T0+2 of a frame -> load_o=0 from T0+3; no en_o; frame_cnt unchanged; in_ready=1 at T0+3.
- Async reset mid-frame: drop rst between clock edges during SHIFT -> load_o, serial_out and busy go 0 and frame_cnt goes 0 immediately; after release, a new word 4'h6 is accepted and sent correctly.
